// File: rtl/io_arbiter_if.sv
// io_arbiter_if: bus bundle between the two IO masters, the IO space and the arbiter.
// The slave modport is the arbiter's view; the master modport is the
// requester/IO-space side (a testbench or the surrounding SoC glue).
interface io_arbiter_if #(
    parameter int RAM_DEPTH = 14
);
    // Master 0 (CPU data path)
    logic                 m0_req;
    logic                 m0_we;
    logic                 m0_re;
    logic [RAM_DEPTH-1:0] m0_addr;
    logic [31:0]          m0_wd;
    logic                 m0_ack;
    logic                 m0_err;
    logic [31:0]          m0_rd;

    // Master 1 (debug / loader)
    logic                 m1_req;
    logic                 m1_we;
    logic                 m1_re;
    logic [RAM_DEPTH-1:0] m1_addr;
    logic [31:0]          m1_wd;
    logic                 m1_ack;
    logic                 m1_err;
    logic [31:0]          m1_rd;

    // Shared IO request port
    logic                 io_req;
    logic                 io_we;
    logic                 io_re;
    logic                 dbe;
    logic [RAM_DEPTH-1:0] io_addr;
    logic [31:0]          io_wd;
    logic [31:0]          io_rd;
    logic                 busy;

    modport slave (
        input  m0_req, m0_we, m0_re, m0_addr, m0_wd,
        output m0_ack, m0_err, m0_rd,
        input  m1_req, m1_we, m1_re, m1_addr, m1_wd,
        output m1_ack, m1_err, m1_rd,
        output io_req, io_we, io_re, dbe, io_addr, io_wd, busy,
        input  io_rd
    );

    modport master (
        output m0_req, m0_we, m0_re, m0_addr, m0_wd,
        input  m0_ack, m0_err, m0_rd,
        output m1_req, m1_we, m1_re, m1_addr, m1_wd,
        input  m1_ack, m1_err, m1_rd,
        input  io_req, io_we, io_re, dbe, io_addr, io_wd, busy,
        output io_rd
    );
endinterface

// File: rtl/io_arbiter.sv
// io_arbiter: two-master arbiter/sequencer for the IO address space.
// Each access runs IDLE -> ISSUE -> RESP -> IDLE (3 cycles). Bad accesses
// (address >= IO_LIMIT, or WE and RE together) are flagged on DBE with the
// strobes suppressed, and reported back to the owner as ERR.
// Optional feature macro: IO_ARB_RR_EN selects round-robin arbitration;
// when undefined, master 0 has fixed priority with a HOLD_MAX starvation guard.
module io_arbiter #(
    parameter int RAM_DEPTH = 14,
    parameter int IO_LIMIT  = 16,
    parameter int HOLD_MAX  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    io_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Address is out of the decoded IO window.
    function automatic logic addr_bad(input logic [RAM_DEPTH-1:0] addr);
        logic [31:0] addr_ext;
        addr_ext = 32'(addr);
        return (addr_ext >= 32'(IO_LIMIT));
    endfunction

    // Access must be suppressed: out-of-range address or contradictory command.
    function automatic logic cmd_bad(input logic we, input logic re,
                                     input logic [RAM_DEPTH-1:0] addr);
        return addr_bad(addr) | (we & re);
    endfunction

    // FSM and holding registers
    state_e               state_q,  state_d;
    logic                 owner_q,  owner_d;   // 0: master 0, 1: master 1
    logic                 we_q,     we_d;
    logic                 re_q,     re_d;
    logic [RAM_DEPTH-1:0] addr_q,   addr_d;
    logic [31:0]          wd_q,     wd_d;
    logic                 err_q,    err_d;

    // Registered outputs
    logic                 io_req_q,  io_req_d;
    logic                 io_we_q,   io_we_d;
    logic                 io_re_q,   io_re_d;
    logic                 dbe_q,     dbe_d;
    logic [RAM_DEPTH-1:0] io_addr_q, io_addr_d;
    logic [31:0]          io_wd_q,   io_wd_d;
    logic                 m0_ack_q,  m0_ack_d;
    logic                 m1_ack_q,  m1_ack_d;
    logic                 m0_err_q,  m0_err_d;
    logic                 m1_err_q,  m1_err_d;
    logic                 busy_q,    busy_d;

    // Arbitration result and the winner's command
    logic                 any_req_s;
    logic                 grant_m1_s;
    logic                 sel_we_s;
    logic                 sel_re_s;
    logic [RAM_DEPTH-1:0] sel_addr_s;
    logic [31:0]          sel_wd_s;
    logic                 sel_err_s;

`ifdef IO_ARB_RR_EN
    // Last-granted master; resets to master 1 so master 0 takes the first contention.
    logic                 ptr_q, ptr_d;
`else
    localparam int SW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [SW-1:0] HOLD_C = SW'(HOLD_MAX);
    localparam logic [SW-1:0] ONE_C  = SW'(1);
    // Consecutive master-0 grants taken while master 1 was waiting.
    logic [SW-1:0]        starve_q, starve_d;
`endif

    assign any_req_s = bus.m0_req | bus.m1_req;

    // Pick the winner among the current requesters.
    always_comb begin
        grant_m1_s = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
`ifdef IO_ARB_RR_EN
            grant_m1_s = ~ptr_q;
`else
            grant_m1_s = (starve_q == HOLD_C);
`endif
        end else if (bus.m1_req) begin
            grant_m1_s = 1'b1;
        end else begin
            grant_m1_s = 1'b0;
        end
    end

    // Route the winner's command toward the holding registers.
    always_comb begin
        sel_we_s   = 1'b0;
        sel_re_s   = 1'b0;
        sel_addr_s = {RAM_DEPTH{1'b0}};
        sel_wd_s   = 32'd0;
        if (grant_m1_s) begin
            sel_we_s   = bus.m1_we;
            sel_re_s   = bus.m1_re;
            sel_addr_s = bus.m1_addr;
            sel_wd_s   = bus.m1_wd;
        end else begin
            sel_we_s   = bus.m0_we;
            sel_re_s   = bus.m0_re;
            sel_addr_s = bus.m0_addr;
            sel_wd_s   = bus.m0_wd;
        end
        sel_err_s = cmd_bad(sel_we_s, sel_re_s, sel_addr_s);
    end

    // Next-state, holding-register and next-output logic for the transaction sequencer.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        re_d      = re_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        err_d     = err_q;
`ifdef IO_ARB_RR_EN
        ptr_d     = ptr_q;
`else
        starve_d  = starve_q;
`endif
        io_req_d  = 1'b0;
        io_we_d   = 1'b0;
        io_re_d   = 1'b0;
        dbe_d     = 1'b0;
        io_addr_d = {RAM_DEPTH{1'b0}};
        io_wd_d   = 32'd0;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        m0_err_d  = 1'b0;
        m1_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d   = ST_ISSUE;
                    owner_d   = grant_m1_s;
                    we_d      = sel_we_s;
                    re_d      = sel_re_s;
                    addr_d    = sel_addr_s;
                    wd_d      = sel_wd_s;
                    err_d     = sel_err_s;
                    // ISSUE outputs are prepared here so they are registered on entry.
                    io_req_d  = 1'b1;
                    io_we_d   = sel_we_s & ~sel_err_s;
                    io_re_d   = sel_re_s & ~sel_err_s;
                    dbe_d     = sel_err_s;
                    io_addr_d = sel_addr_s;
                    io_wd_d   = sel_wd_s;
`ifdef IO_ARB_RR_EN
                    ptr_d     = grant_m1_s;
`else
                    if (grant_m1_s) begin
                        starve_d = {SW{1'b0}};
                    end else if (bus.m1_req) begin
                        starve_d = (starve_q == HOLD_C) ? starve_q : (starve_q + ONE_C);
                    end else begin
                        starve_d = {SW{1'b0}};
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d  = ST_RESP;
                m0_ack_d = ~owner_q;
                m1_ack_d = owner_q;
                m0_err_d = ~owner_q & err_q;
                m1_err_d = owner_q & err_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, holding registers and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            addr_q    <= {RAM_DEPTH{1'b0}};
            wd_q      <= 32'd0;
            err_q     <= 1'b0;
            io_req_q  <= 1'b0;
            io_we_q   <= 1'b0;
            io_re_q   <= 1'b0;
            dbe_q     <= 1'b0;
            io_addr_q <= {RAM_DEPTH{1'b0}};
            io_wd_q   <= 32'd0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            re_q      <= re_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            io_req_q  <= io_req_d;
            io_we_q   <= io_we_d;
            io_re_q   <= io_re_d;
            dbe_q     <= dbe_d;
            io_addr_q <= io_addr_d;
            io_wd_q   <= io_wd_d;
            m0_ack_q  <= m0_ack_d;
            m1_ack_q  <= m1_ack_d;
            m0_err_q  <= m0_err_d;
            m1_err_q  <= m1_err_d;
            busy_q    <= busy_d;
        end
    end

`ifdef IO_ARB_RR_EN
    // Round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Starvation counter for master 1 under fixed priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= {SW{1'b0}};
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Read data arrives from the IO space during RESP, so it is passed through
    // combinationally, gated to the owner of an error-free read.
    always_comb begin
        bus.m0_rd = 32'd0;
        bus.m1_rd = 32'd0;
        if (re_q && !err_q) begin
            bus.m0_rd = m0_ack_q ? bus.io_rd : 32'd0;
            bus.m1_rd = m1_ack_q ? bus.io_rd : 32'd0;
        end else begin
            bus.m0_rd = 32'd0;
            bus.m1_rd = 32'd0;
        end
    end

    assign bus.io_req  = io_req_q;
    assign bus.io_we   = io_we_q;
    assign bus.io_re   = io_re_q;
    assign bus.dbe     = dbe_q;
    assign bus.io_addr = io_addr_q;
    assign bus.io_wd   = io_wd_q;
    assign bus.m0_ack  = m0_ack_q;
    assign bus.m1_ack  = m1_ack_q;
    assign bus.m0_err  = m0_err_q;
    assign bus.m1_err  = m1_err_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: directed bench for io_arbiter (default fixed-priority build).
module tb_io_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    io_arbiter_if #(.RAM_DEPTH(14)) bus ();

    io_arbiter #(
        .RAM_DEPTH(14),
        .IO_LIMIT (16),
        .HOLD_MAX (4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drop_all();
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_re = 1'b0;
        bus.m0_addr = 14'd0; bus.m0_wd = 32'd0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_re = 1'b0;
        bus.m1_addr = 14'd0; bus.m1_wd = 32'd0;
        bus.io_rd = 32'd0;
    endtask

    // Bounds the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] exp_m1_order;
        n_tests = 0;
        n_fail  = 0;
        drop_all();
        rst = 1'b1;
        tick();
        tick();
        // Reset state
        chk1("rst_io_req", bus.io_req, 1'b0);
        chk1("rst_busy",   bus.busy,   1'b0);
        chk1("rst_m0_ack", bus.m0_ack, 1'b0);
        chk1("rst_dbe",    bus.dbe,    1'b0);
        rst = 1'b0;
        tick();

        // 1. Master 0 write
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 14'd0; bus.m0_wd = 32'h000000A5;
        chk1("w_busy0", bus.busy, 1'b0);
        tick();
        chk1 ("w_io_req",  bus.io_req,  1'b1);
        chk1 ("w_io_we",   bus.io_we,   1'b1);
        chk1 ("w_io_re",   bus.io_re,   1'b0);
        chk32("w_io_addr", 32'(bus.io_addr), 32'd0);
        chk32("w_io_wd",   bus.io_wd,   32'h000000A5);
        chk1 ("w_dbe",     bus.dbe,     1'b0);
        chk1 ("w_busy1",   bus.busy,    1'b1);
        chk1 ("w_ack_early", bus.m0_ack, 1'b0);
        tick();
        chk1("w_m0_ack",  bus.m0_ack, 1'b1);
        chk1("w_m0_err",  bus.m0_err, 1'b0);
        chk1("w_busy2",   bus.busy,   1'b1);
        chk1("w_io_req2", bus.io_req, 1'b0);
        drop_all();
        tick();
        chk1("w_busy3",  bus.busy,   1'b0);
        chk1("w_ack_end", bus.m0_ack, 1'b0);

        // 2. Master 1 read
        bus.m1_req = 1'b1; bus.m1_re = 1'b1; bus.m1_addr = 14'd3;
        tick();
        chk1 ("r_io_re",   bus.io_re, 1'b1);
        chk1 ("r_io_we",   bus.io_we, 1'b0);
        chk32("r_io_addr", 32'(bus.io_addr), 32'd3);
        bus.io_rd = 32'h12345678;
        tick();
        chk1 ("r_m1_ack", bus.m1_ack, 1'b1);
        chk32("r_m1_rd",  bus.m1_rd,  32'h12345678);
        chk1 ("r_m1_err", bus.m1_err, 1'b0);
        chk1 ("r_m0_ack", bus.m0_ack, 1'b0);
        chk32("r_m0_rd",  bus.m0_rd,  32'd0);
        drop_all();
        tick();

        // 3. Errors: out-of-range write, then WE+RE together
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 14'd16; bus.m0_wd = 32'hDEADBEEF;
        tick();
        chk1 ("e_dbe",     bus.dbe,    1'b1);
        chk1 ("e_io_we",   bus.io_we,  1'b0);
        chk1 ("e_io_req",  bus.io_req, 1'b1);
        chk32("e_io_addr", 32'(bus.io_addr), 32'd16);
        tick();
        chk1("e_m0_ack", bus.m0_ack, 1'b1);
        chk1("e_m0_err", bus.m0_err, 1'b1);
        drop_all();
        tick();
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_re = 1'b1; bus.m1_addr = 14'd2;
        tick();
        chk1("e2_dbe",   bus.dbe,   1'b1);
        chk1("e2_io_we", bus.io_we, 1'b0);
        chk1("e2_io_re", bus.io_re, 1'b0);
        bus.io_rd = 32'hFFFFFFFF;
        tick();
        chk1 ("e2_m1_ack", bus.m1_ack, 1'b1);
        chk1 ("e2_m1_err", bus.m1_err, 1'b1);
        chk32("e2_m1_rd",  bus.m1_rd,  32'd0);
        drop_all();
        tick();
        // Highest legal address reads normally
        bus.m0_req = 1'b1; bus.m0_re = 1'b1; bus.m0_addr = 14'd15;
        tick();
        chk1("b_dbe",   bus.dbe,   1'b0);
        chk1("b_io_re", bus.io_re, 1'b1);
        bus.io_rd = 32'hCAFEF00D;
        tick();
        chk32("b_m0_rd",  bus.m0_rd,  32'hCAFEF00D);
        chk1 ("b_m0_err", bus.m0_err, 1'b0);
        chk32("b_m1_rd",  bus.m1_rd,  32'd0);
        drop_all();
        tick();
        // No-op request: pulse without strobes, no error
        bus.m1_req = 1'b1; bus.m1_addr = 14'd1;
        tick();
        chk1("n_io_req", bus.io_req, 1'b1);
        chk1("n_io_we",  bus.io_we,  1'b0);
        chk1("n_io_re",  bus.io_re,  1'b0);
        chk1("n_dbe",    bus.dbe,    1'b0);
        tick();
        chk1("n_m1_ack", bus.m1_ack, 1'b1);
        chk1("n_m1_err", bus.m1_err, 1'b0);
        drop_all();
        tick();

        // 4. Contention from a clean reset: M0 x4, M1, M0 x4, M1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        exp_m1_order = 10'b10_0001_0000;
        bus.m0_req = 1'b1; bus.m0_re = 1'b1; bus.m0_addr = 14'd1;
        bus.m1_req = 1'b1; bus.m1_re = 1'b1; bus.m1_addr = 14'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk32($sformatf("c_addr%0d", i), 32'(bus.io_addr),
                  exp_m1_order[i] ? 32'd2 : 32'd1);
            tick();
            chk1($sformatf("c_m0_ack%0d", i), bus.m0_ack, ~exp_m1_order[i]);
            chk1($sformatf("c_m1_ack%0d", i), bus.m1_ack,  exp_m1_order[i]);
            if (i == 9) begin
                drop_all();
            end
            tick();
        end

        // 5. Reset during ISSUE
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 14'd5; bus.m0_wd = 32'h55;
        tick();
        chk1("x_io_req_pre", bus.io_req, 1'b1);
        rst = 1'b1;
        #1;
        chk1("x_io_req_async", bus.io_req, 1'b0);
        chk1("x_busy_async",   bus.busy,   1'b0);
        drop_all();
        bus.m1_req = 1'b1; bus.m1_re = 1'b1; bus.m1_addr = 14'd7;
        tick();
        chk1("x_no_ack", bus.m0_ack, 1'b0);
        rst = 1'b0;
        tick();
        chk1 ("x_m1_io_req", bus.io_req, 1'b1);
        chk1 ("x_m1_io_re",  bus.io_re,  1'b1);
        chk32("x_m1_addr",   32'(bus.io_addr), 32'd7);
        bus.io_rd = 32'h0BADBEEF;
        tick();
        chk1 ("x_m1_ack", bus.m1_ack, 1'b1);
        chk32("x_m1_rd",  bus.m1_rd,  32'h0BADBEEF);
        chk1 ("x_m0_ack", bus.m0_ack, 1'b0);
        drop_all();
        tick();

        // 6. Back-to-back with new command captured after ACK
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 14'd4; bus.m0_wd = 32'h11111111;
        tick();
        chk32("bb_wd1",   bus.io_wd, 32'h11111111);
        chk1 ("bb_we1",   bus.io_we, 1'b1);
        tick();
        chk1("bb_ack1", bus.m0_ack, 1'b1);
        bus.m0_we = 1'b0; bus.m0_re = 1'b1; bus.m0_addr = 14'd9; bus.m0_wd = 32'h22222222;
        bus.io_rd = 32'h5A5A5A5A;
        tick();
        chk1("bb_idle_req", bus.io_req, 1'b0);
        chk1("bb_idle_ack", bus.m0_ack, 1'b0);
        tick();
        chk1 ("bb_io_req2", bus.io_req, 1'b1);
        chk32("bb_addr2",   32'(bus.io_addr), 32'd9);
        chk1 ("bb_re2",     bus.io_re, 1'b1);
        chk1 ("bb_we2",     bus.io_we, 1'b0);
        chk32("bb_wd2",     bus.io_wd, 32'h22222222);
        tick();
        chk1 ("bb_ack2", bus.m0_ack, 1'b1);
        chk32("bb_rd2",  bus.m0_rd,  32'h5A5A5A5A);
        drop_all();
        tick();
        chk1("bb_busy_end", bus.busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_arbiter.md
Name: io_arbiter

Overview:
- Two-master arbiter and sequencer for the IO address space.
- Shares the single IO request port (IO_REQ/IO_WE/IO_RE/IO_ADDR/IO_WD/DBE, read data back on IO_RD) between master 0 (CPU data path) and master 1 (debug/loader).
- Runs each access as a fixed three-cycle transaction with a one-cycle ACK pulse.
- Flags out-of-range or malformed accesses through DBE, so the IO space ignores them.

Parameters:
- RAM_DEPTH, 14: IO address width in bits.
- IO_LIMIT, 16: number of decoded IO addresses. ADDR >= IO_LIMIT is an error.
- HOLD_MAX, 4: maximum consecutive master-0 grants while master 1 waits (fixed-priority mode only).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- M0_REQ  in  1  master 0 request; held high with its command until M0_ACK.
- M0_WE  in  1  master 0 write.
- M0_RE  in  1  master 0 read.
- M0_ADDR  in  RAM_DEPTH  master 0 address.
- M0_WD  in  32  master 0 write data.
- M0_ACK  out  1  one-cycle completion pulse to master 0.
- M0_ERR  out  1  error flag, valid with M0_ACK.
- M0_RD  out  32  read data, valid with M0_ACK.
- M1_REQ, M1_WE, M1_RE, M1_ADDR, M1_WD, M1_ACK, M1_ERR, M1_RD: same as master 0, for master 1.
- IO_REQ  out  1  request to the IO space.
- IO_WE  out  1  write strobe.
- IO_RE  out  1  read strobe.
- DBE  out  1  bus error / suppress access.
- IO_ADDR  out  RAM_DEPTH  address.
- IO_WD  out  32  write data.
- IO_RD  in  32  read data; valid the cycle after IO_REQ.
- BUSY  out  1  high when state != IDLE.

Behaviour:
- States: IDLE -> ISSUE -> RESP -> IDLE. Each transaction is 3 cycles; maximum throughput is one access per 3 cycles.
- IDLE:
  - If any REQ is high, select a winner and register owner, command, address and write data into holding registers; go to ISSUE.
  - If no REQ is high, stay in IDLE.
- ISSUE (1 cycle):
  - IO_REQ=1; IO_WE, IO_RE, IO_ADDR, IO_WD driven from the holding registers.
  - DBE=1 if the held address >= IO_LIMIT, or if both WE and RE are set. In that case IO_WE and IO_RE are forced to 0.
  - REQ with neither WE nor RE: IO_REQ still pulses with WE=RE=0 (no-op); completes normally with ERR=0.
- RESP (1 cycle):
  - Owner's ACK=1.
  - Owner's ERR = the registered error.
  - Owner's RD = IO_RD if the access was a read without error, else 0.
  - Non-owner ACK, ERR and RD are 0.
- All IO_* outputs and DBE are 0 outside ISSUE. M*_ACK, M*_ERR and M*_RD are 0 outside RESP.
- Master protocol:
  - Master keeps REQ and its command stable until it sees ACK.
  - REQ still high in the cycle after ACK is sampled in IDLE as a new transaction.
  - Changes to the command after the IDLE capture have no effect on the transaction in flight.
- Arbitration (default, fixed priority):
  - Master 0 wins over master 1.
  - starve_cnt counts consecutive master-0 grants made while M1_REQ is high.
  - When starve_cnt == HOLD_MAX and both request, master 1 wins.
  - starve_cnt clears on any master-1 grant, and on any IDLE capture with M1_REQ low.
  - starve_cnt saturates at HOLD_MAX.
- A single requester is always granted immediately, regardless of the counter.
- Reset (asynchronous, any state including mid-transaction):
  - State goes to IDLE; all outputs 0; holding registers, starve_cnt and the RR pointer are cleared.
  - No ACK is issued for an aborted transaction.
  - Deassertion is sampled on the next rising edge.

Optional Feature:
- Macro IO_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer holds the last-granted master. On contention the other master wins.
  - The pointer updates on every grant and resets to master 1, so master 0 wins the first contention.
  - starve_cnt and HOLD_MAX are unused.
- Undefined: fixed priority with the HOLD_MAX starvation guard, as in Behaviour.

Test Plan:
1. Write: M0 write, ADDR=0, WD=0x000000A5 in cycle 0 -> cycle 1: IO_REQ=1, IO_WE=1, IO_ADDR=0, IO_WD=0xA5, DBE=0; cycle 2: M0_ACK=1, M0_ERR=0; BUSY high in cycles 1-2.
2. Read: M1 read, ADDR=3, IO_RD=0x12345678 in cycle 2 -> M1_ACK=1 and M1_RD=0x12345678 in cycle 2; M0_ACK=0 and M0_RD=0.
3. Error: M0 write to ADDR=IO_LIMIT (16) -> ISSUE has DBE=1, IO_WE=0; RESP has M0_ACK=1, M0_ERR=1. A separate access with WE=RE=1 also gives ERR=1.
4. Contention, fixed priority, HOLD_MAX=4: M0 and M1 both request continuously -> grant order M0, M0, M0, M0, M1, M0, M0, M0, M0, M1. Under IO_ARB_RR_EN the order is M0, M1, M0, M1.
5. Reset mid-operation: assert RESET during ISSUE -> IO_REQ drops immediately (asynchronously), no ACK is issued; after release, a pending M1_REQ is granted within 1 cycle and completes normally.
6. Back-to-back: M0 holds REQ through its ACK -> second transaction ISSUE lands 3 cycles after the first, and the new command values are captured.
